// File: rtl/period_meter_pkg.sv
// Shared encodings for the period meter and anything that reuses its front end.
package period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into clk domain and flags its rising/falling edges.
// Both edges see the same latency, so intervals between edges are preserved.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ClkIn,
    input  logic Reset_n,
    input  logic SigIn,
    output logic Rise,
    output logic Fall,
    output logic Level
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge ClkIn or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SigIn};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign Level = sync_q[SYNC_STAGES-1];
    assign Rise  = Level & ~prev_q;
    assign Fall  = ~Level & prev_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous square wave in ClkIn cycles.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | disabled; counters cleared, results held, Overflow cleared
// ST_ARM  | waiting for the reference rising edge
// ST_MEAS | counting; each rising edge publishes a result and restarts
module period_meter
    import period_meter_pkg::*;
#(
    parameter int CW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          ClkIn,
    input  logic          Reset_n,
    input  logic          SigIn,
    input  logic          Enable,
    output logic [CW-1:0] PeriodOut,
    output logic [CW-1:0] HighOut,
    output logic          ValidOut,
    output logic          Overflow
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   high_lat_q;
    logic [CW-1:0]   period_q;
    logic [CW-1:0]   high_q;
    logic            valid_q;
    logic            ovf_q;
    logic            rise;
    logic            fall;
    logic            level_unused;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_detect (
        .ClkIn  (ClkIn),
        .Reset_n(Reset_n),
        .SigIn  (SigIn),
        .Rise   (rise),
        .Fall   (fall),
        .Level  (level_unused)
    );

    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge ClkIn or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_lat_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                ovf_q <= 1'b0;
            end
            if (!Enable) begin
                state_q    <= ST_IDLE;
                cnt_q      <= '0;
                high_lat_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARM;
                    end
                    ST_ARM: begin
                        if (rise) begin
                            cnt_q      <= '0;
                            high_lat_q <= '0;
                            state_q    <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        // Saturation wins so the wrapped cnt+1 is never published.
                        if (cnt_q == CNT_MAX) begin
                            ovf_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_ARM;
                        end else if (rise) begin
                            period_q <= cnt_d;
                            high_q   <= high_lat_q;
                            valid_q  <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                            if (fall) begin
                                high_lat_q <= cnt_d;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign PeriodOut = period_q;
    assign HighOut   = high_q;
    assign ValidOut  = valid_q;
    assign Overflow  = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_period_meter;

    localparam int CW = 8;
    localparam int NS = 2;

    logic          ClkIn   = 1'b0;
    logic          Reset_n = 1'b0;
    logic          SigIn   = 1'b0;
    logic          Enable  = 1'b0;
    logic [CW-1:0] PeriodOut;
    logic [CW-1:0] HighOut;
    logic          ValidOut;
    logic          Overflow;

    period_meter #(
        .CW         (CW),
        .SYNC_STAGES(NS)
    ) dut (
        .ClkIn    (ClkIn),
        .Reset_n  (Reset_n),
        .SigIn    (SigIn),
        .Enable   (Enable),
        .PeriodOut(PeriodOut),
        .HighOut  (HighOut),
        .ValidOut (ValidOut),
        .Overflow (Overflow)
    );

    always #5 ClkIn = ~ClkIn;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Stimulus generator: constant level or periodic wave (div cycles, high for first 'high').
    int g_mode = 0;
    int g_div  = 8;
    int g_high = 4;
    int g_ph   = 0;
    bit g_level = 1'b0;

    always @(negedge ClkIn) begin
        if (g_mode == 1) begin
            g_ph  = (g_ph + 1) % g_div;
            SigIn = (g_ph < g_high);
        end else begin
            SigIn = g_level;
        end
    end

    // Reference model: edges are timestamped on the raw samples of SigIn and act two
    // cycles later; results are differences of timestamps.
    longint cyc = 0;
    longint ref_t = 0;
    longint fall_t = 0;
    bit     m_ref = 0, m_fall = 0, m_valid = 0, m_ovf = 0;
    int     m_period = 0, m_high = 0;
    bit     h1 = 0, h2 = 0, h3 = 0, en_prev = 0;
    bit     e_rise, e_fall, listen;

    always @(posedge ClkIn) begin
        if (!Reset_n) begin
            m_ref = 0; m_fall = 0; m_valid = 0; m_ovf = 0;
            m_period = 0; m_high = 0;
            h1 = 0; h2 = 0; h3 = 0; en_prev = 0;
        end else begin
            cyc++;
            e_rise  = h2 & ~h3;
            e_fall  = ~h2 & h3;
            listen  = Enable && en_prev;
            m_valid = 0;
            if (!en_prev) m_ovf = 0;
            if (!listen) begin
                m_ref = 0;
            end else if (m_ref && (cyc - ref_t) == longint'(2**CW)) begin
                m_ovf = 1;
                m_ref = 0;
            end else if (e_rise) begin
                if (m_ref) begin
                    m_period = int'(cyc - ref_t);
                    m_high   = m_fall ? int'(fall_t - ref_t) : 0;
                    m_valid  = 1;
                end
                ref_t  = cyc;
                m_ref  = 1;
                m_fall = 0;
            end else if (e_fall && m_ref) begin
                fall_t = cyc;
                m_fall = 1;
            end
            en_prev = Enable;
            h3 = h2; h2 = h1; h1 = SigIn;
            #1;
            if (Reset_n) begin
                check("model_period", int'(PeriodOut), m_period);
                check("model_high",   int'(HighOut),   m_high);
                check("model_valid",  int'(ValidOut),  int'(m_valid));
                check("model_ovf",    int'(Overflow),  int'(m_ovf));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ClkIn);
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge ClkIn);
            #2;
            if (ValidOut) begin
                ok = 1;
                break;
            end
        end
        check(name, int'(ok), 1);
    endtask

    task automatic count_valid(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge ClkIn);
            #2;
            c += int'(ValidOut);
        end
    endtask

    int c;

    initial begin
        Reset_n = 0;
        Enable  = 0;
        tick(3);
        check("rst_period", int'(PeriodOut), 0);
        check("rst_high",   int'(HighOut),   0);
        check("rst_valid",  int'(ValidOut),  0);
        check("rst_ovf",    int'(Overflow),  0);

        Reset_n = 1;
        Enable  = 1;
        g_div = 8; g_high = 4; g_mode = 1;
        tick(30);
        wait_valid("div8_valid", 20);
        check("div8_period", int'(PeriodOut), 8);
        check("div8_high",   int'(HighOut),   4);
        count_valid(80, c);
        check("div8_rate", c, 10);

        tick(1);
        g_div = 64; g_high = 32;
        tick(200);
        wait_valid("div64_valid", 80);
        check("div64_period", int'(PeriodOut), 64);
        check("div64_high",   int'(HighOut),   32);

        tick(1);
        g_div = 8; g_high = 2;
        tick(40);
        wait_valid("duty25_valid", 20);
        check("duty25_period", int'(PeriodOut), 8);
        check("duty25_high",   int'(HighOut),   2);

        tick(1);
        g_div = 2; g_high = 1;
        tick(20);
        wait_valid("div2_valid", 10);
        check("div2_period", int'(PeriodOut), 2);
        check("div2_high",   int'(HighOut),   1);
        count_valid(20, c);
        check("div2_rate", c, 10);

        tick(1);
        g_div = 8; g_high = 4;
        tick(20);
        wait_valid("pre_drop_valid", 20);
        tick(3);
        Enable = 0;
        count_valid(20, c);
        check("drop_no_valid", c, 0);
        check("drop_hold_period", int'(PeriodOut), 8);
        check("drop_hold_high",   int'(HighOut),   4);
        tick(1);
        Enable = 1;
        count_valid(8, c);
        check("reen_no_early_valid", c, 0);
        wait_valid("reen_valid", 20);
        check("reen_period", int'(PeriodOut), 8);

        tick(1);
        Enable = 0;
        g_mode = 0; g_level = 0;
        tick(5);
        Enable = 1;
        tick(5);
        g_level = 1;
        count_valid(240, c);
        check("sat_no_valid_a", c, 0);
        check("sat_not_yet",    int'(Overflow), 0);
        count_valid(40, c);
        check("sat_no_valid_b", c, 0);
        check("sat_ovf",        int'(Overflow), 1);

        tick(1);
        g_div = 8; g_high = 4; g_mode = 1;
        wait_valid("post_sat_valid", 40);
        check("post_sat_period", int'(PeriodOut), 8);
        check("post_sat_ovf",    int'(Overflow),  1);

        tick(1);
        Enable = 0;
        tick(2);
        Enable = 1;
        tick(2);
        check("ovf_cleared", int'(Overflow), 0);

        tick(13);
        #2;
        Reset_n = 0;
        #1;
        check("async_rst_period", int'(PeriodOut), 0);
        check("async_rst_high",   int'(HighOut),   0);
        check("async_rst_valid",  int'(ValidOut),  0);
        check("async_rst_ovf",    int'(Overflow),  0);
        tick(3);
        Reset_n = 1;
        count_valid(8, c);
        check("post_rst_no_early_valid", c, 0);
        wait_valid("post_rst_valid", 30);
        check("post_rst_period", int'(PeriodOut), 8);
        check("post_rst_high",   int'(HighOut),   4);

        tick(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
